// File: rtl/mipi_tx_pkg.sv
// Shared types and constants for the MIPI CSI-2 TX frame controller.
package mipi_tx_pkg;

  typedef enum logic [3:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_VS,
    ST_VS_GAP,
    ST_HS,
    ST_HS_GAP,
    ST_LINE,
    ST_HBLANK,
    ST_FGAP
  } state_e;

  localparam logic [5:0] CSI_RAW8           = 6'h2A;
  localparam logic [5:0] CSI_RGB888         = 6'h24;
  localparam logic       FRAME_MODE_GENERIC = 1'b0;

  // Frame configuration captured at frame start.
  typedef struct packed {
    logic [15:0] hres;
    logic [15:0] line_words;
    logic [15:0] lines;
    logic [5:0]  dtype;
    logic [1:0]  vc;
    logic [1:0]  lanes;
  } frame_cfg_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mipi_tx_rst_seq.sv
// Power-up reset release for the MIPI TX hard block: DPHY reset first,
// controller reset a fixed lag later; done follows the controller reset.
module mipi_tx_rst_seq #(
  parameter int RST_CYCLES = 1024,
  parameter int RSTN_LAG   = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic dphy_rstn,
  output logic mipi_rstn,
  output logic done
);

  localparam int CNT_W = $clog2(RST_CYCLES + RSTN_LAG + 1);
  localparam logic [CNT_W-1:0] DPHY_AT = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RSTN_AT = CNT_W'(RST_CYCLES + RSTN_LAG - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dphy_q, dphy_d;
  logic             rstn_q, rstn_d;

  // The counter freezes once the controller reset has been released.
  always_comb begin
    cnt_d  = cnt_q;
    dphy_d = dphy_q;
    rstn_d = rstn_q;
    if (!rstn_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == DPHY_AT) dphy_d = 1'b1;
      if (cnt_q == RSTN_AT) rstn_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dphy_q <= 1'b0;
      rstn_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dphy_q <= dphy_d;
      rstn_q <= rstn_d;
    end
  end

  assign dphy_rstn = dphy_q;
  assign mipi_rstn = rstn_q;
  assign done      = rstn_q;

endmodule

// File: rtl/mipi_tx_frame_ctrl.sv
// Frame sequencer for the MIPI CSI-2 TX hard block: reset release, then
// VSYNC/HSYNC/VALID timing with payload pulled from a ready/valid stream.
module mipi_tx_frame_ctrl
  import mipi_tx_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int RST_CYCLES = 1024,
  parameter int RSTN_LAG   = 16,
  parameter int VS_CYCLES  = 8,
  parameter int VS_TO_HS   = 16,
  parameter int HS_CYCLES  = 4,
  parameter int HS_TO_DATA = 8,
  parameter int HBLANK     = 32,
  parameter int FRAME_GAP  = 64
) (
  input  logic              tx_pixel_clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic [15:0]       cfg_hres,
  input  logic [15:0]       cfg_line_words,
  input  logic [15:0]       cfg_lines,
  input  logic [5:0]        cfg_type,
  input  logic [1:0]        cfg_vc,
  input  logic [1:0]        cfg_lanes,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] mipi_tx_DATA,
  output logic              mipi_tx_VALID,
  output logic              mipi_tx_HSYNC,
  output logic              mipi_tx_VSYNC,
  output logic [15:0]       mipi_tx_HRES,
  output logic [5:0]        mipi_tx_TYPE,
  output logic [1:0]        mipi_tx_VC,
  output logic [1:0]        mipi_tx_LANES,
  output logic              mipi_tx_FRAME_MODE,
  output logic              mipi_tx_RSTN,
  output logic              mipi_tx_DPHY_RSTN,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err,
  output logic [15:0]       frame_cnt
);

  localparam int TMR_MAX = max_int(max_int(max_int(VS_CYCLES, VS_TO_HS),
                                           max_int(HS_CYCLES, HS_TO_DATA)),
                                   max_int(HBLANK, FRAME_GAP));
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] VS_LAST  = TMR_W'(VS_CYCLES - 1);
  localparam logic [TMR_W-1:0] V2H_LAST = TMR_W'(VS_TO_HS - 1);
  localparam logic [TMR_W-1:0] HS_LAST  = TMR_W'(HS_CYCLES - 1);
  localparam logic [TMR_W-1:0] H2D_LAST = TMR_W'(HS_TO_DATA - 1);
  localparam logic [TMR_W-1:0] HB_LAST  = TMR_W'(HBLANK - 1);
  localparam logic [TMR_W-1:0] FG_LAST  = TMR_W'(FRAME_GAP - 1);

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [15:0]       beat_q, beat_d;
  logic [15:0]       line_q, line_d;
  frame_cfg_t        cfg_q, cfg_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              vsync_q, vsync_d;
  logic              hsync_q, hsync_d;
  logic              frame_done_q, frame_done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              rst_done;
  logic              beat_fire;

  mipi_tx_rst_seq #(
    .RST_CYCLES (RST_CYCLES),
    .RSTN_LAG   (RSTN_LAG)
  ) u_rst_seq (
    .clk       (tx_pixel_clk),
    .rst_n     (rstn),
    .dphy_rstn (mipi_tx_DPHY_RSTN),
    .mipi_rstn (mipi_tx_RSTN),
    .done      (rst_done)
  );

  // Ready drops as soon as the line's beat count is reached.
  assign s_ready   = (state_q == ST_LINE) && (beat_q < cfg_q.line_words);
  assign beat_fire = s_valid && s_ready;

  always_comb begin
    state_d      = state_q;
    tmr_d        = '0;
    beat_d       = beat_q;
    line_d       = line_q;
    cfg_d        = cfg_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_done_d = 1'b0;
    cfg_err_d    = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      ST_PWRUP: if (rst_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (enable) begin
          cfg_d = {cfg_hres, cfg_line_words, cfg_lines, cfg_type, cfg_vc, cfg_lanes};
          if ((cfg_lines == 16'd0) || (cfg_line_words == 16'd0)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = ST_VS;
            beat_d  = '0;
            line_d  = '0;
          end
        end
      end
      ST_VS:     if (tmr_q == VS_LAST)  state_d = ST_VS_GAP; else tmr_d = tmr_q + 1'b1;
      ST_VS_GAP: if (tmr_q == V2H_LAST) state_d = ST_HS;     else tmr_d = tmr_q + 1'b1;
      ST_HS:     if (tmr_q == HS_LAST)  state_d = ST_HS_GAP; else tmr_d = tmr_q + 1'b1;
      ST_HS_GAP: if (tmr_q == H2D_LAST) state_d = ST_LINE;   else tmr_d = tmr_q + 1'b1;
      ST_LINE: begin
        if (beat_fire) begin
          valid_d = 1'b1;
          data_d  = s_data;
          if (beat_q == cfg_q.line_words - 16'd1) begin
            beat_d  = '0;
            line_d  = line_q + 16'd1;
            state_d = ST_HBLANK;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end
      end
      ST_HBLANK: begin
        if (tmr_q == HB_LAST) state_d = (line_q == cfg_q.lines) ? ST_FGAP : ST_HS;
        else                  tmr_d   = tmr_q + 1'b1;
      end
      ST_FGAP: begin
        if (tmr_q == FG_LAST) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
    // Syncs follow the next state so they are registered yet aligned to it.
    vsync_d = (state_d == ST_VS);
    hsync_d = (state_d == ST_HS);
  end

  always_ff @(posedge tx_pixel_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_PWRUP;
      tmr_q        <= '0;
      beat_q       <= '0;
      line_q       <= '0;
      cfg_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      vsync_q      <= 1'b0;
      hsync_q      <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      cfg_q        <= cfg_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      vsync_q      <= vsync_d;
      hsync_q      <= hsync_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign mipi_tx_DATA       = data_q;
  assign mipi_tx_VALID      = valid_q;
  assign mipi_tx_VSYNC      = vsync_q;
  assign mipi_tx_HSYNC      = hsync_q;
  assign mipi_tx_HRES       = cfg_q.hres;
  assign mipi_tx_TYPE       = cfg_q.dtype;
  assign mipi_tx_VC         = cfg_q.vc;
  assign mipi_tx_LANES      = cfg_q.lanes;
  assign mipi_tx_FRAME_MODE = FRAME_MODE_GENERIC;
  assign busy               = (state_q != ST_PWRUP) && (state_q != ST_IDLE);
  assign frame_done         = frame_done_q;
  assign cfg_err            = cfg_err_q;
  assign frame_cnt          = frame_cnt_q;

endmodule

// File: tb/tb_mipi_tx_frame_ctrl.sv
// Bench for mipi_tx_frame_ctrl: frame-shape table plus a segment-queue
// reference model checked every cycle, and hand-written corner sequences.
module tb_mipi_tx_frame_ctrl;
  import mipi_tx_pkg::*;

  localparam int DW = 64, RST_C = 16, LAG = 4, VS_C = 2, V2H = 3;
  localparam int HS_C = 2, H2D = 2, HB = 4, FG = 5;
  localparam int PW_DONE = RST_C + LAG + 1;
  localparam int K_VS = 1, K_GAP = 2, K_HS = 3, K_LINE = 4;

  logic          clk = 1'b0, rstn = 1'b1, enable = 1'b0;
  logic [15:0]   cfg_hres = '0, cfg_line_words = '0, cfg_lines = '0;
  logic [5:0]    cfg_type = '0;
  logic [1:0]    cfg_vc = '0, cfg_lanes = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, mipi_tx_VALID, mipi_tx_HSYNC, mipi_tx_VSYNC, mipi_tx_FRAME_MODE;
  logic          mipi_tx_RSTN, mipi_tx_DPHY_RSTN, busy, frame_done, cfg_err;
  logic [DW-1:0] mipi_tx_DATA;
  logic [15:0]   mipi_tx_HRES, frame_cnt;
  logic [5:0]    mipi_tx_TYPE;
  logic [1:0]    mipi_tx_VC, mipi_tx_LANES;

  always #5 clk = ~clk;

  mipi_tx_frame_ctrl #(
    .DATA_W(DW), .RST_CYCLES(RST_C), .RSTN_LAG(LAG), .VS_CYCLES(VS_C), .VS_TO_HS(V2H),
    .HS_CYCLES(HS_C), .HS_TO_DATA(H2D), .HBLANK(HB), .FRAME_GAP(FG)
  ) dut (
    .tx_pixel_clk(clk), .rstn(rstn), .enable(enable), .cfg_hres(cfg_hres),
    .cfg_line_words(cfg_line_words), .cfg_lines(cfg_lines), .cfg_type(cfg_type),
    .cfg_vc(cfg_vc), .cfg_lanes(cfg_lanes), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .mipi_tx_DATA(mipi_tx_DATA), .mipi_tx_VALID(mipi_tx_VALID),
    .mipi_tx_HSYNC(mipi_tx_HSYNC), .mipi_tx_VSYNC(mipi_tx_VSYNC), .mipi_tx_HRES(mipi_tx_HRES),
    .mipi_tx_TYPE(mipi_tx_TYPE), .mipi_tx_VC(mipi_tx_VC), .mipi_tx_LANES(mipi_tx_LANES),
    .mipi_tx_FRAME_MODE(mipi_tx_FRAME_MODE), .mipi_tx_RSTN(mipi_tx_RSTN),
    .mipi_tx_DPHY_RSTN(mipi_tx_DPHY_RSTN), .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err), .frame_cnt(frame_cnt)
  );

  // A frame is a queue of timed segments; a LINE segment ends on its Nth accepted beat.
  typedef struct {int kind; int cnt;} seg_t;
  typedef struct {int words; int lines; int vmode; int exp_len; int exp_beats; int exp_cnt;} vec_t;

  seg_t          seg_q[$];
  vec_t          vecs[6];
  int            n_checks, n_errors, m_pw;
  bit            e_valid, e_done, e_err;
  logic [DW-1:0] e_data;
  logic [15:0]   e_cnt, e_hres;
  logic [5:0]    e_type;
  logic [1:0]    e_vc, e_lanes;
  int unsigned   pay_idx, salt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int unsigned i);
    return {i ^ salt, ~i};
  endfunction

  function automatic void push_seg(input int k, input int n);
    seg_t s;
    s.kind = k;
    s.cnt  = n;
    seg_q.push_back(s);
  endfunction

  task automatic model_reset();
    seg_q.delete();
    m_pw = 0; e_valid = 0; e_done = 0; e_err = 0; e_data = '0; e_cnt = '0;
    e_hres = '0; e_type = '0; e_vc = '0; e_lanes = '0;
  endtask

  task automatic model_edge();
    seg_t s;
    e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (m_pw < PW_DONE) begin
      m_pw++;
    end else if (seg_q.size() == 0) begin
      if (enable) begin
        e_hres = cfg_hres; e_type = cfg_type; e_vc = cfg_vc; e_lanes = cfg_lanes;
        if (cfg_lines == 0 || cfg_line_words == 0) begin
          e_err = 1'b1;
        end else begin
          push_seg(K_VS, VS_C);
          push_seg(K_GAP, V2H);
          for (int ln = 0; ln < int'(cfg_lines); ln++) begin
            push_seg(K_HS, HS_C);
            push_seg(K_GAP, H2D);
            push_seg(K_LINE, int'(cfg_line_words));
            push_seg(K_GAP, HB);
          end
          push_seg(K_GAP, FG);
        end
      end
    end else begin
      s = seg_q[0];
      if (s.kind == K_LINE) begin
        if (s_valid) begin
          e_valid = 1'b1; e_data = s_data; pay_idx++; s.cnt--;
        end
      end else begin
        s.cnt--;
      end
      if (s.cnt == 0) begin
        void'(seg_q.pop_front());
        if (seg_q.size() == 0) begin
          e_done = 1'b1;
          e_cnt  = e_cnt + 16'd1;
        end
      end else begin
        seg_q[0] = s;
      end
    end
  endtask

  task automatic compare();
    bit f;
    int k;
    f = (seg_q.size() != 0);
    k = f ? seg_q[0].kind : 0;
    check("ctrl", 128'({mipi_tx_VSYNC, mipi_tx_HSYNC, s_ready, mipi_tx_VALID, busy, frame_done, cfg_err}),
          128'({k == K_VS, k == K_HS, k == K_LINE, e_valid, f, e_done, e_err}));
    if (e_valid) check("data", 128'(mipi_tx_DATA), 128'(e_data));
    check("cfg", 128'({mipi_tx_HRES, mipi_tx_TYPE, mipi_tx_VC, mipi_tx_LANES, mipi_tx_FRAME_MODE}),
          128'({e_hres, e_type, e_vc, e_lanes, FRAME_MODE_GENERIC}));
    check("rst_pins", 128'({mipi_tx_DPHY_RSTN, mipi_tx_RSTN}), 128'({m_pw >= RST_C, m_pw >= RST_C + LAG}));
    check("frame_cnt", 128'(frame_cnt), 128'(e_cnt));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic check_all_zero(input string name);
    check(name, 128'({mipi_tx_DATA, mipi_tx_VALID, mipi_tx_HSYNC, mipi_tx_VSYNC, mipi_tx_HRES,
                      mipi_tx_TYPE, mipi_tx_VC, mipi_tx_LANES, mipi_tx_FRAME_MODE, mipi_tx_RSTN,
                      mipi_tx_DPHY_RSTN, busy, frame_done, cfg_err, frame_cnt, s_ready}), 128'(0));
  endtask

  // vmode: 0 always valid, 1 alternating, 2 random; mid_type is driven once the frame is running.
  task automatic run_frame(input int vmode, input logic [5:0] mid_type, output int len, output int beats);
    int t_vs;
    len = -1; beats = 0; t_vs = -1;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (seg_q.size() != 0) begin
        enable   = 1'b0;
        cfg_type = mid_type;
      end
      case (vmode)
        0:       s_valid = 1'b1;
        1:       s_valid = (i % 2 == 0);
        default: s_valid = ($urandom_range(0, 9) < 7);
      endcase
      s_data = mk_data(pay_idx);
      step();
      if (mipi_tx_VSYNC && t_vs < 0) t_vs = i;
      if (mipi_tx_VALID) beats++;
      if (frame_done) begin
        len = i - t_vs;
        break;
      end
    end
    check("frame_done_seen", 128'(len >= 0), 128'(1));
    s_valid = 1'b0;
    enable  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, beats, err_seen, vs_seen, w, l;
    bit hit;
    n_checks = 0; n_errors = 0; pay_idx = 0; salt = $urandom;
    model_reset();
    vecs[0] = '{4, 2, 0, 34, 8, 1};
    vecs[1] = '{1, 1, 0, 19, 1, 2};
    vecs[2] = '{3, 1, 0, 21, 3, 3};
    vecs[3] = '{2, 3, 0, 40, 6, 4};
    vecs[4] = '{4, 2, 1, 0, 8, 5};
    vecs[5] = '{5, 1, 0, 23, 5, 6};

    #1 rstn = 1'b0;
    @(negedge clk);
    check_all_zero("reset_state");
    rstn = 1'b1;

    repeat (RST_C - 1) step();
    check("dphy_low_before", 128'(mipi_tx_DPHY_RSTN), 128'(0));
    step();
    check("dphy_rise", 128'(mipi_tx_DPHY_RSTN), 128'(1));
    check("rstn_low_lag", 128'(mipi_tx_RSTN), 128'(0));
    repeat (LAG - 1) step();
    check("rstn_still_low", 128'(mipi_tx_RSTN), 128'(0));
    step();
    check("rstn_rise", 128'(mipi_tx_RSTN), 128'(1));
    check("busy_pwrup", 128'({busy, mipi_tx_VSYNC, mipi_tx_VALID}), 128'(0));
    step();

    foreach (vecs[r]) begin
      cfg_line_words = 16'(vecs[r].words);
      cfg_lines      = 16'(vecs[r].lines);
      cfg_type       = CSI_RAW8;
      cfg_hres       = 16'($urandom);
      cfg_vc         = 2'($urandom);
      cfg_lanes      = 2'($urandom);
      run_frame(vecs[r].vmode, CSI_RAW8, len, beats);
      if (vecs[r].exp_len != 0) check("frame_len", 128'(len), 128'(vecs[r].exp_len));
      check("beats", 128'(beats), 128'(vecs[r].exp_beats));
      check("frame_cnt_tbl", 128'(frame_cnt), 128'(vecs[r].exp_cnt));
    end

    cfg_lines = 16'd0; cfg_line_words = 16'd4; enable = 1'b1;
    err_seen = 0; vs_seen = 0;
    repeat (6) begin
      s_valid = 1'b1;
      s_data  = mk_data(pay_idx);
      step();
      err_seen += int'(cfg_err);
      vs_seen  += int'(mipi_tx_VSYNC);
    end
    check("cfg_err_pulses", 128'(err_seen), 128'(6));
    check("no_vsync_on_err", 128'(vs_seen), 128'(0));
    cfg_lines = 16'd1;
    run_frame(0, CSI_RAW8, len, beats);
    check("beats_after_err", 128'(beats), 128'(4));

    cfg_type = CSI_RAW8; cfg_line_words = 16'd3; cfg_lines = 16'd2;
    run_frame(0, CSI_RGB888, len, beats);
    check("type_held", 128'(mipi_tx_TYPE), 128'(CSI_RAW8));
    run_frame(2, CSI_RGB888, len, beats);
    check("type_next", 128'(mipi_tx_TYPE), 128'(CSI_RGB888));

    repeat (6) begin
      w = $urandom_range(1, 6);
      l = $urandom_range(1, 3);
      cfg_line_words = 16'(w);
      cfg_lines      = 16'(l);
      cfg_type       = ($urandom_range(0, 1) == 1) ? CSI_RAW8 : CSI_RGB888;
      cfg_hres       = 16'($urandom);
      cfg_vc         = 2'($urandom);
      cfg_lanes      = 2'($urandom);
      run_frame(2, 6'($urandom), len, beats);
      check("beats_rand", 128'(beats), 128'(w * l));
    end

    cfg_line_words = 16'd4; cfg_lines = 16'd2; cfg_type = CSI_RAW8; enable = 1'b1; hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (seg_q.size() != 0) enable = 1'b0;
      s_valid = 1'b1;
      s_data  = mk_data(pay_idx);
      step();
      if (seg_q.size() != 0 && seg_q[0].kind == K_LINE && seg_q[0].cnt <= 2) hit = 1'b1;
    end
    check("reached_line", 128'(hit), 128'(1));
    #2 rstn = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    s_valid = 1'b0; enable = 1'b0;
    @(negedge clk);
    check_all_zero("reset_held");
    rstn = 1'b1;
    repeat (PW_DONE) step();
    check("frame_cnt_after_reset", 128'(frame_cnt), 128'(0));
    check("rstn_after_reset", 128'({mipi_tx_DPHY_RSTN, mipi_tx_RSTN}), 128'(3));
    run_frame(0, CSI_RAW8, len, beats);
    check("beats_post_reset", 128'(beats), 128'(8));
    check("len_post_reset", 128'(len), 128'(34));
    check("cnt_post_reset", 128'(frame_cnt), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
